// File: rtl/axi_io_slave_if.sv
// rtl/axi_io_slave_if.sv - AXI4-Lite channel bundle between a bus master and axi_io_slave
interface axi_io_slave_if;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_io_slave.sv
// rtl/axi_io_slave.sv - AXI4-Lite byte I/O slave with RX/TX FIFOs; AXI_IO_SLAVE_STATUS_EN adds a status register at 0x8
module axi_io_slave #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    axi_io_slave_if.slave s_axi,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_VALID,
    output logic          RX_READY,
    output logic [7:0]    TX_DATA,
    output logic          TX_VALID,
    input  logic          TX_READY
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH       = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;

    r_state_t r_state, r_state_next;
    w_state_t w_state, w_state_next;

    // Held low through reset so the idle-state ready decodes stay deasserted.
    logic live;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [AW:0]   rx_count;
    logic          rx_push, rx_pop, rx_empty, rx_full;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [AW:0]   tx_count;
    logic          tx_push, tx_pop, tx_empty, tx_full;

    logic [3:0]  ar_off, aw_off;
    logic [7:0]  w_byte;
    logic        w_strb0;
    logic        aw_done, w_done;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        ar_hs, aw_hs, w_hs, b_hs;
    logic        rd_load, wr_exec;
    logic [31:0] rd_value;
    logic [1:0]  rd_resp, wr_resp;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi.S_AXI_AWADDR[31:4], s_axi.S_AXI_ARADDR[31:4],
                             s_axi.S_AXI_WDATA[31:8], s_axi.S_AXI_WSTRB[3:1]};

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == DEPTH);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == DEPTH);

    assign RX_READY = live && !rx_full;
    assign TX_VALID = !tx_empty;
    assign TX_DATA  = tx_mem[tx_rd_ptr];
    assign rx_push  = RX_VALID && RX_READY;
    assign tx_pop   = TX_VALID && TX_READY;

    assign s_axi.S_AXI_ARREADY = live && (r_state == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_state == R_RESP);
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_AWREADY = live && (w_state == W_IDLE) && !aw_done;
    assign s_axi.S_AXI_WREADY  = live && (w_state == W_IDLE) && !w_done;
    assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp;

    assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign b_hs  = s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            live    <= 1'b0;
        end else begin
            r_state <= r_state_next;
            w_state <= w_state_next;
            live    <= 1'b1;
        end
    end

    always_comb begin
        r_state_next = r_state;
        rd_load      = 1'b0;
        rx_pop       = 1'b0;
        rd_value     = '0;
        rd_resp      = RESP_SLVERR;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_next = R_WAIT;
            R_WAIT: begin
                if (ar_off == 4'h0) begin
                    // An RXDATA read parks here until a byte arrives.
                    if (!rx_empty) begin
                        rd_load  = 1'b1;
                        rx_pop   = 1'b1;
                        rd_value = {24'h0, rx_mem[rx_rd_ptr]};
                        rd_resp  = RESP_OKAY;
                    end
                end
`ifdef AXI_IO_SLAVE_STATUS_EN
                else if (ar_off == 4'h8) begin
                    rd_load  = 1'b1;
                    rd_value = {30'h0, !tx_full, !rx_empty};
                    rd_resp  = RESP_OKAY;
                end
`endif
                else begin
                    rd_load = 1'b1;
                end
                if (rd_load) r_state_next = R_RESP;
            end
            R_RESP: if (s_axi.S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_next = w_state;
        wr_exec      = 1'b0;
        tx_push      = 1'b0;
        wr_resp      = RESP_SLVERR;
        case (w_state)
            W_IDLE: if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_next = W_EXEC;
            W_EXEC: begin
                if (aw_off == 4'h4) begin
                    if (!tx_full) begin
                        wr_exec = 1'b1;
                        tx_push = w_strb0;
                        wr_resp = RESP_OKAY;
                    end
                end else begin
                    wr_exec = 1'b1;
                end
                if (wr_exec) w_state_next = W_RESP;
            end
            W_RESP: if (s_axi.S_AXI_BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ar_off  <= '0;
            aw_off  <= '0;
            w_byte  <= '0;
            w_strb0 <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            bresp   <= RESP_OKAY;
        end else begin
            if (ar_hs) ar_off <= s_axi.S_AXI_ARADDR[3:0];
            if (rd_load) begin
                rdata <= rd_value;
                rresp <= rd_resp;
            end
            if (aw_hs) begin
                aw_off  <= s_axi.S_AXI_AWADDR[3:0];
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_byte  <= s_axi.S_AXI_WDATA[7:0];
                w_strb0 <= s_axi.S_AXI_WSTRB[0];
                w_done  <= 1'b1;
            end
            if (wr_exec) bresp <= wr_resp;
            if (b_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= RX_DATA;
        if (tx_push) tx_mem[tx_wr_ptr] <= w_byte;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_io_slave.sv
// tb/tb_axi_io_slave.sv - self-checking bench for axi_io_slave against a queue-based model
module tb_axi_io_slave;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_VALID = 1'b0;
    logic       RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY = 1'b0;

    axi_io_slave_if bus ();

    axi_io_slave #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .s_axi    (bus),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY)
    );

    always #5 CLK = ~CLK;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         status_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_rx_ready"}, RX_READY, rx_q.size() < DEPTH);
        chk({tag, "_tx_valid"}, TX_VALID, tx_q.size() != 0);
    endtask

    task automatic push_rx(input logic [7:0] b);
        int n = 0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (!RX_READY && n < 40) begin @(negedge CLK); n++; end
        chk("rx_push_ready", n < 40, 1);
        @(negedge CLK);
        RX_VALID = 1'b0;
        rx_q.push_back(b);
    endtask

    task automatic pop_tx(input string tag);
        int n = 0;
        logic [7:0] e;
        while (!TX_VALID && n < 40) begin @(negedge CLK); n++; end
        chk({tag, "_tx_valid"}, TX_VALID, 1);
        e = tx_q.pop_front();
        chk({tag, "_tx_data"}, TX_DATA, e);
        TX_READY = 1'b1;
        @(negedge CLK);
        TX_READY = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] a);
        int n = 0;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge CLK); n++; end
        chk("ar_handshake", n < 50, 1);
        @(negedge CLK);
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic r_wait(output bit got, output int lat);
        lat = 0;
        while (!bus.S_AXI_RVALID && lat < 60) begin @(negedge CLK); lat++; end
        got = bus.S_AXI_RVALID;
    endtask

    task automatic r_accept();
        bus.S_AXI_RREADY = 1'b1;
        @(negedge CLK);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    // Reads whose outcome is known immediately; expected result comes from the model.
    task automatic rd(input logic [31:0] a, input string tag);
        logic [31:0] ed;
        logic [1:0]  er;
        bit          got;
        int          lat;
        ed = '0;
        er = 2'b10;
        if (a[3:0] == 4'h0) begin
            ed = {24'h0, rx_q.pop_front()};
            er = 2'b00;
        end else if (a[3:0] == 4'h8 && status_en) begin
            ed = {30'h0, tx_q.size() < DEPTH, rx_q.size() != 0};
            er = 2'b00;
        end
        ar_issue(a);
        r_wait(got, lat);
        chk({tag, "_rvalid"}, got, 1);
        chk({tag, "_latency"}, lat, 1);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        chk({tag, "_rdata"}, bus.S_AXI_RDATA, ed);
        chk({tag, "_rresp"}, bus.S_AXI_RRESP, er);
        r_accept();
    endtask

    // order: 0 AW and W together, 1 W first, 2 AW first
    task automatic w_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int order);
        bit aw_ok = 0, w_ok = 0, aw_f, w_f;
        int n = 0;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = (order != 1);
        bus.S_AXI_WVALID  = (order != 2);
        while (!(aw_ok && w_ok) && n < 50) begin
            aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge CLK);
            n++;
            if (aw_f) begin aw_ok = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_f)  begin w_ok = 1;  bus.S_AXI_WVALID  = 1'b0; end
            if (w_ok && !aw_ok) bus.S_AXI_AWVALID = 1'b1;
            if (aw_ok && !w_ok) bus.S_AXI_WVALID  = 1'b1;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("w_handshake", aw_ok && w_ok, 1);
    endtask

    task automatic b_wait(input int limit, output bit got, output logic [1:0] resp);
        int n = 0;
        while (!bus.S_AXI_BVALID && n < limit) begin @(negedge CLK); n++; end
        got  = bus.S_AXI_BVALID;
        resp = bus.S_AXI_BRESP;
        if (got) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            resp = bus.S_AXI_BRESP;
            bus.S_AXI_BREADY = 1'b1;
            @(negedge CLK);
            bus.S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int order, input string tag);
        bit         got;
        logic [1:0] resp, er;
        er = 2'b10;
        if (a[3:0] == 4'h4) begin
            er = 2'b00;
            if (s[0]) tx_q.push_back(d[7:0]);
        end
        w_issue(a, d, s, order);
        b_wait(40, got, resp);
        chk({tag, "_bvalid"}, got, 1);
        chk({tag, "_bresp"}, resp, er);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] hi, d;
        logic [3:0]  off;
        int          op;

`ifdef AXI_IO_SLAVE_STATUS_EN
        status_en = 1'b1;
`else
        status_en = 1'b0;
`endif
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_arready", bus.S_AXI_ARREADY, 0);
        chk("rst_awready", bus.S_AXI_AWREADY, 0);
        chk("rst_wready", bus.S_AXI_WREADY, 0);
        chk("rst_rvalid", bus.S_AXI_RVALID, 0);
        chk("rst_bvalid", bus.S_AXI_BVALID, 0);
        chk("rst_rdata", bus.S_AXI_RDATA, 0);
        chk("rst_rresp", bus.S_AXI_RRESP, 0);
        chk("rst_bresp", bus.S_AXI_BRESP, 0);
        chk("rst_rx_ready", RX_READY, 0);
        chk("rst_tx_valid", TX_VALID, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rel_arready", bus.S_AXI_ARREADY, 1);
        chk("rel_awready", bus.S_AXI_AWREADY, 1);
        chk("rel_wready", bus.S_AXI_WREADY, 1);
        chk("rel_rx_ready", RX_READY, 1);

        push_rx(8'h5A);
        rd(32'h0, "rx_5a");
        check_flags("after_rx_5a");

        fork
            begin
                ar_issue(32'h0);
                r_wait(got, lat);
            end
            begin
                repeat (10) @(negedge CLK);
                push_rx(8'h33);
            end
        join
        chk("blocked_rvalid", got, 1);
        chk("blocked_waited", lat >= 10, 1);
        chk("blocked_rdata", bus.S_AXI_RDATA, {24'h0, rx_q.pop_front()});
        chk("blocked_rresp", bus.S_AXI_RRESP, 0);
        r_accept();

        wr(32'h4, 32'h0000_00C3, 4'b0001, 1, "tx_c3");
        pop_tx("tx_c3");

        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom();
            wr(32'h4, d, 4'b0001, i % 3, "fill");
        end
        d = $urandom();
        w_issue(32'h4, d, 4'b1111, 0);
        b_wait(12, got, resp);
        chk("full_bvalid_withheld", got, 0);
        pop_tx("full_pop");
        b_wait(40, got, resp);
        chk("full_late_bvalid", got, 1);
        chk("full_late_bresp", resp, 0);
        tx_q.push_back(d[7:0]);
        while (tx_q.size() != 0) pop_tx("drain");

        push_rx(8'h11);
        wr(32'h4, 32'h22, 4'b0001, 2, "pre_err");
        rd(32'hC, "rd_unmapped_c");
        wr(32'h0, 32'hFF, 4'b1111, 0, "wr_rxdata");
        rd(32'h4, "rd_txdata");
        wr(32'h8, 32'h1, 4'b1111, 1, "wr_status");
        check_flags("after_errs");
        rd(32'h0, "rx_kept");
        pop_tx("tx_kept");
        rd(32'h8, "status_empty");

        push_rx(8'h44);
        fork
            rd(32'h0, "conc_rd");
            wr(32'h4, 32'h55, 4'b0001, 0, "conc_wr");
        join
        pop_tx("conc_tx");

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 5);
            hi = $urandom();
            case (op)
                0: if (rx_q.size() < DEPTH) push_rx(8'($urandom()));
                1: if (rx_q.size() != 0) rd({hi[31:4], 4'h0}, "rand_rx");
                2: if (tx_q.size() < DEPTH) wr({hi[31:4], 4'h4}, $urandom(), 4'($urandom()),
                                             $urandom_range(0, 2), "rand_tx");
                3: if (tx_q.size() != 0) pop_tx("rand_pop");
                4: begin
                    off = 4'($urandom_range(1, 15));
                    rd({hi[31:4], off}, "rand_rd_other");
                end
                default: begin
                    off = 4'($urandom_range(0, 15));
                    if (off == 4'h4) off = 4'h5;
                    wr({hi[31:4], off}, $urandom(), 4'($urandom()), $urandom_range(0, 2), "rand_wr_other");
                end
            endcase
            if (i % 8 == 7) check_flags("rand");
        end

        push_rx(8'h77);
        ar_issue(32'h0);
        r_wait(got, lat);
        chk("pre_reset_rvalid", got, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_reset_rvalid", bus.S_AXI_RVALID, 0);
        chk("mid_reset_arready", bus.S_AXI_ARREADY, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        rx_q.delete();
        tx_q.delete();
        chk("post_reset_arready", bus.S_AXI_ARREADY, 1);
        check_flags("post_reset");
        push_rx(8'h99);
        rd(32'h0, "post_reset_rx");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
